// File: rtl/regbank_pkg.sv
// Shared defaults and encodings for the scoreboarded register bank.
package regbank_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned NUM_REGS_DEF = 16;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_LAST = NUM_REGS_DEF - 1;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_WAW,
    ERR_SPURIOUS_RSP,
    ERR_COLLIDE
  } err_cause_e;

endpackage

// File: rtl/sb_scoreboard.sv
// Busy scoreboard for outstanding loads: set on issue, clear on response, flush clears all.
module sb_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                rsp_valid,
  input  logic [ADDR_W-1:0]   rsp_addr,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   lookup_a,
  input  logic [ADDR_W-1:0]   lookup_b,
  input  logic [ADDR_W-1:0]   lookup_wr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                issue_ready,
  output logic                rsp_accept,
  output logic                busy_a,
  output logic                busy_b,
  output logic                busy_wr
);

  localparam bit Z0 = (ZERO_R0 != 0);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                set_ok;

  always_comb begin
    rsp_accept = rsp_valid && busy_q[rsp_addr];
    // A response retiring the same register frees it for a back-to-back issue.
    issue_ready = !busy_q[issue_addr] || (rsp_accept && (rsp_addr == issue_addr)) ||
                  (Z0 && (issue_addr == '0));
    set_ok = issue_valid && issue_ready && !flush && !(Z0 && (issue_addr == '0));

    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (rsp_accept) busy_d[rsp_addr] = 1'b0;
      if (set_ok) busy_d[issue_addr] = 1'b1;
    end
    if (Z0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_a   = busy_q[lookup_a];
  assign busy_b   = busy_q[lookup_b];
  assign busy_wr  = busy_q[lookup_wr];

endmodule

// File: rtl/regbank_sb.sv
// Parametrised register bank with two bypassed read ports, ALU and load write ports,
// and a load scoreboard that stalls reads of registers still awaiting data.
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd_a_en,
  input  logic [ADDR_W-1:0]   rd_a_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  input  logic                rd_b_en,
  input  logic [ADDR_W-1:0]   rd_b_addr,
  output logic [DATA_W-1:0]   rd_b_data,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                ld_issue_valid,
  input  logic [ADDR_W-1:0]   ld_issue_addr,
  output logic                ld_issue_ready,
  input  logic                ld_rsp_valid,
  input  logic [ADDR_W-1:0]   ld_rsp_addr,
  input  logic [DATA_W-1:0]   ld_rsp_data,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                err
);

  localparam bit Z0 = (ZERO_R0 != 0);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              rsp_accept, busy_a, busy_b, busy_wr;
  logic              wr_ok, rsp_hit_a, rsp_hit_b;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_val  [2];
  err_cause_e        err_cause;
  logic              err_q;

  sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_R0  (ZERO_R0)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (ld_issue_valid),
    .issue_addr  (ld_issue_addr),
    .rsp_valid   (ld_rsp_valid),
    .rsp_addr    (ld_rsp_addr),
    .flush       (flush),
    .lookup_a    (rd_a_addr),
    .lookup_b    (rd_b_addr),
    .lookup_wr   (wr_addr),
    .busy_vec    (busy_vec),
    .issue_ready (ld_issue_ready),
    .rsp_accept  (rsp_accept),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .busy_wr     (busy_wr)
  );

  always_comb begin
    // Load response owns its destination this cycle, so a colliding ALU write loses.
    wr_ok = wr_en && !busy_wr && !(ld_rsp_valid && (ld_rsp_addr == wr_addr)) &&
            !(Z0 && (wr_addr == '0));

    err_cause = ERR_NONE;
    if (ld_rsp_valid && !rsp_accept) begin
      err_cause = ERR_SPURIOUS_RSP;
    end else if (wr_en && busy_wr) begin
      err_cause = ERR_WAW;
    end else if (wr_en && ld_rsp_valid && (ld_rsp_addr == wr_addr)) begin
      err_cause = ERR_COLLIDE;
    end
  end

  assign rd_addr[0] = rd_a_addr;
  assign rd_addr[1] = rd_b_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = regs_q[rd_addr[p]];
      if (Z0 && (rd_addr[p] == '0)) begin
        rd_val[p] = '0;
      end else if (ld_rsp_valid && (ld_rsp_addr == rd_addr[p])) begin
        rd_val[p] = ld_rsp_data;
      end else if (wr_ok && (wr_addr == rd_addr[p])) begin
        rd_val[p] = wr_data;
      end
    end
  end

  assign rd_a_data = rd_val[0];
  assign rd_b_data = rd_val[1];

  assign rsp_hit_a = ld_rsp_valid && (ld_rsp_addr == rd_a_addr);
  assign rsp_hit_b = ld_rsp_valid && (ld_rsp_addr == rd_b_addr);
  assign stall     = (rd_a_en && busy_a && !rsp_hit_a) || (rd_b_en && busy_b && !rsp_hit_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (rsp_accept) regs_q[ld_rsp_addr] <= ld_rsp_data;
      if (wr_ok) regs_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (err_cause != ERR_NONE);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_regbank_sb.sv
// Self-checking bench for regbank_sb: vector table plus hand-written corner sequences.
module tb_regbank_sb;

  logic        clk, reset;
  logic        rd_a_en, rd_b_en, wr_en, ld_issue_valid, ld_rsp_valid, flush;
  logic [3:0]  rd_a_addr, rd_b_addr, wr_addr, ld_issue_addr, ld_rsp_addr;
  logic [15:0] wr_data, ld_rsp_data;
  logic [15:0] rd_a_data, rd_b_data, busy_vec;
  logic        ld_issue_ready, stall, err;
  logic [15:0] z_rd_a_data, z_rd_b_data, z_busy_vec;
  logic        z_ready, z_stall, z_err;

  regbank_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(0)) dut (
    .clk(clk), .reset(reset),
    .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr),
    .ld_issue_ready(ld_issue_ready),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_addr(ld_rsp_addr), .ld_rsp_data(ld_rsp_data),
    .flush(flush), .stall(stall), .busy_vec(busy_vec), .err(err)
  );

  regbank_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(1)) dut_z (
    .clk(clk), .reset(reset),
    .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(z_rd_a_data),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(z_rd_b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_addr(ld_issue_addr),
    .ld_issue_ready(z_ready),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_addr(ld_rsp_addr), .ld_rsp_data(ld_rsp_data),
    .flush(flush), .stall(z_stall), .busy_vec(z_busy_vec), .err(z_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr_en;   logic [3:0] wa;  logic [15:0] wd;
    logic        iv;      logic [3:0] ia;
    logic        rv;      logic [3:0] rsa; logic [15:0] rsd;
    logic        fl;
    logic        ae;      logic [3:0] ra;
    logic        be;      logic [3:0] rb;
    logic [15:0] ea;      logic [15:0] eb;
    logic        est;     logic       erdy;
    logic [15:0] ebusy;   logic       eerr;
  } vec_t;

  typedef struct packed {
    logic [15:0] busy;
    logic        err;
  } exp_reg_t;

  int total = 0;
  int bad = 0;
  exp_reg_t exp_q[$];
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    ld_issue_valid = 0; ld_issue_addr = 0;
    ld_rsp_valid = 0; ld_rsp_addr = 0; ld_rsp_data = 0;
    flush = 0; rd_a_en = 0; rd_a_addr = 0; rd_b_en = 0; rd_b_addr = 0;
  endtask

  initial begin
    exp_reg_t e;
    // wr_en wa wd | iv ia | rv rsa rsd | fl | ae ra | be rb | ea eb | stall rdy | busy err
    vecs[0]  = '{1, 3, 16'h1234, 0, 0, 0, 0, 0,        0, 0, 0, 1, 3, 16'h0000, 16'h1234, 0, 1, 16'h0000, 0};
    vecs[1]  = '{0, 0, 0,        1, 5, 0, 0, 0,        0, 1, 3, 0, 0, 16'h1234, 16'h0000, 0, 1, 16'h0020, 0};
    vecs[2]  = '{0, 0, 0,        0, 5, 0, 0, 0,        0, 1, 5, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0020, 0};
    vecs[3]  = '{0, 0, 0,        0, 0, 1, 5, 16'hBEEF, 0, 1, 5, 0, 0, 16'hBEEF, 16'h0000, 0, 1, 16'h0000, 0};
    vecs[4]  = '{0, 0, 0,        1, 5, 0, 0, 0,        0, 0, 5, 0, 0, 16'hBEEF, 16'h0000, 0, 1, 16'h0020, 0};
    vecs[5]  = '{1, 5, 16'h0001, 1, 7, 0, 0, 0,        0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h00A0, 1};
    vecs[6]  = '{1, 2, 16'h2222, 0, 0, 1, 7, 16'h7777, 0, 1, 5, 1, 7, 16'hBEEF, 16'h7777, 1, 1, 16'h0020, 0};
    vecs[7]  = '{0, 0, 0,        0, 0, 1, 5, 16'h5555, 0, 1, 2, 1, 7, 16'h2222, 16'h7777, 0, 1, 16'h0000, 0};
    vecs[8]  = '{0, 0, 0,        1, 1, 0, 0, 0,        0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0002, 0};
    vecs[9]  = '{0, 0, 0,        1, 2, 0, 0, 0,        0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0006, 0};
    vecs[10] = '{0, 0, 0,        1, 4, 0, 0, 0,        1, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 16'h0000, 0};
    vecs[11] = '{0, 0, 0,        0, 0, 1, 1, 16'hAAAA, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 1};
    vecs[12] = '{0, 0, 0,        0, 0, 0, 0, 0,        0, 1, 1, 1, 2, 16'h0000, 16'h2222, 0, 1, 16'h0000, 0};
    vecs[13] = '{0, 0, 0,        1, 6, 0, 0, 0,        0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0040, 0};
    vecs[14] = '{1, 6, 16'h9999, 0, 0, 1, 6, 16'h6666, 0, 1, 6, 0, 0, 16'h6666, 16'h0000, 0, 1, 16'h0000, 1};
    vecs[15] = '{0, 0, 0,        0, 0, 0, 0, 0,        0, 1, 6, 0, 0, 16'h6666, 16'h0000, 0, 1, 16'h0000, 0};
    vecs[16] = '{0, 0, 0,        1, 8, 0, 0, 0,        0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0100, 0};
    vecs[17] = '{0, 0, 0,        1, 8, 1, 8, 16'h8888, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h0100, 0};
    vecs[18] = '{0, 0, 0,        0, 0, 1, 8, 16'h8889, 0, 1, 8, 0, 0, 16'h8889, 16'h0000, 0, 1, 16'h0000, 0};
    vecs[19] = '{0, 0, 0,        0, 0, 0, 0, 0,        0, 1, 8, 1, 3, 16'h8889, 16'h1234, 0, 1, 16'h0000, 0};

    idle();
    reset = 1'b1;
    #1;
    chk("reset_busy", 32'(busy_vec), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_ready", 32'(ld_issue_ready), 32'h1);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_rd_a", 32'(rd_a_data), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      ld_issue_valid = vecs[i].iv; ld_issue_addr = vecs[i].ia;
      ld_rsp_valid = vecs[i].rv; ld_rsp_addr = vecs[i].rsa; ld_rsp_data = vecs[i].rsd;
      flush = vecs[i].fl;
      rd_a_en = vecs[i].ae; rd_a_addr = vecs[i].ra;
      rd_b_en = vecs[i].be; rd_b_addr = vecs[i].rb;
      exp_q.push_back('{busy: vecs[i].ebusy, err: vecs[i].eerr});
      #1;
      chk($sformatf("v%0d_rd_a", i), 32'(rd_a_data), 32'(vecs[i].ea));
      chk($sformatf("v%0d_rd_b", i), 32'(rd_b_data), 32'(vecs[i].eb));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].est));
      chk($sformatf("v%0d_ready", i), 32'(ld_issue_ready), 32'(vecs[i].erdy));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_busy", i), 32'(busy_vec), 32'(e.busy));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(e.err));
    end

    // r0 hardwired to zero: writes and load issues to r0 have no effect.
    idle();
    wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF;
    ld_issue_valid = 1; ld_issue_addr = 0;
    rd_a_en = 1; rd_a_addr = 0;
    #1;
    chk("z_rd_a_bypass", 32'(z_rd_a_data), 32'h0);
    chk("z_ready", 32'(z_ready), 32'h1);
    chk("z_stall", 32'(z_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("z_busy0", 32'(z_busy_vec[0]), 32'h0);
    chk("z_err", 32'(z_err), 32'h0);
    idle();
    rd_a_en = 1; rd_a_addr = 0;
    #1;
    chk("z_rd_a_store", 32'(z_rd_a_data), 32'h0);
    chk("z_stall_after", 32'(z_stall), 32'h0);
    chk("nz_rd_a_store", 32'(rd_a_data), 32'hFFFF);

    // Async reset with a load pending clears state before the next edge.
    idle();
    ld_issue_valid = 1; ld_issue_addr = 9;
    @(posedge clk);
    #1;
    chk("pend_busy9", 32'(busy_vec[9]), 32'h1);
    idle();
    rd_a_addr = 3; rd_b_addr = 8;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_vec), 32'h0);
    chk("arst_rd_a", 32'(rd_a_data), 32'h0);
    chk("arst_rd_b", 32'(rd_b_data), 32'h0);
    chk("arst_z_busy", 32'(z_busy_vec), 32'h0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    ld_rsp_valid = 1; ld_rsp_addr = 9; ld_rsp_data = 16'h9999;
    @(posedge clk);
    #1;
    chk("late_rsp_err", 32'(err), 32'h1);
    idle();
    rd_a_addr = 9;
    #1;
    chk("late_rsp_dropped", 32'(rd_a_data), 32'h0);
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
